// File: rtl/line_engine_pkg.sv
// Shared definitions for the line-draw engine and the IO block that feeds it.
// Holds the FSM encoding, default widths and the memory-mapped register addresses.
package line_engine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2
   } le_state_t;

   localparam int LE_COORD_W = 10;
   localparam int LE_COLOR_W = 24;

   // Loads from STATUS return LE_ready; the *_GO stores also fire LE_trigger.
   localparam logic [31:0] LE_ADDR_STATUS = 32'h8000_0024;
   localparam logic [31:0] LE_ADDR_COLOR  = 32'h8000_0028;
   localparam logic [31:0] LE_ADDR_X0     = 32'h8000_002C;
   localparam logic [31:0] LE_ADDR_Y0     = 32'h8000_0030;
   localparam logic [31:0] LE_ADDR_X1     = 32'h8000_0034;
   localparam logic [31:0] LE_ADDR_Y1     = 32'h8000_0038;
   localparam logic [31:0] LE_ADDR_X0_GO  = 32'h8000_003C;
   localparam logic [31:0] LE_ADDR_Y0_GO  = 32'h8000_0040;
   localparam logic [31:0] LE_ADDR_X1_GO  = 32'h8000_0044;
   localparam logic [31:0] LE_ADDR_Y1_GO  = 32'h8000_0048;
   localparam logic [31:0] LE_ADDR_LAST   = 32'h8000_004C;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: picks the major axis, orders the endpoints
// along it and derives the step magnitudes and minor-axis direction.
module line_setup
   import line_engine_pkg::*;
#(
   parameter int COORD_W = LE_COORD_W
) (
   input  logic [COORD_W-1:0]        i_x0,
   input  logic [COORD_W-1:0]        i_y0,
   input  logic [COORD_W-1:0]        i_x1,
   input  logic [COORD_W-1:0]        i_y1,
   output logic                      o_steep,
   output logic [COORD_W-1:0]        o_xa,
   output logic [COORD_W-1:0]        o_ya,
   output logic [COORD_W-1:0]        o_xb,
   output logic signed [COORD_W+1:0] o_dx,
   output logic signed [COORD_W+1:0] o_dy,
   output logic                      o_yUp
);

   logic [COORD_W-1:0] w_adx;
   logic [COORD_W-1:0] w_ady;
   logic [COORD_W-1:0] w_px0;
   logic [COORD_W-1:0] w_py0;
   logic [COORD_W-1:0] w_px1;
   logic [COORD_W-1:0] w_py1;
   logic [COORD_W-1:0] w_yb;

   assign w_adx   = (i_x1 >= i_x0) ? i_x1 - i_x0 : i_x0 - i_x1;
   assign w_ady   = (i_y1 >= i_y0) ? i_y1 - i_y0 : i_y0 - i_y1;
   assign o_steep = w_ady > w_adx;

   // In steep mode the stepper walks along y, so the axes are exchanged here.
   always_comb begin
      w_px0 = i_x0;
      w_py0 = i_y0;
      w_px1 = i_x1;
      w_py1 = i_y1;
      if (o_steep) begin
         w_px0 = i_y0;
         w_py0 = i_x0;
         w_px1 = i_y1;
         w_py1 = i_x1;
      end
      o_xa = w_px0;
      o_ya = w_py0;
      o_xb = w_px1;
      w_yb = w_py1;
      if (w_px0 > w_px1) begin
         o_xa = w_px1;
         o_ya = w_py1;
         o_xb = w_px0;
         w_yb = w_py0;
      end
   end

   assign o_dx  = {2'b00, o_xb - o_xa};
   assign o_dy  = {2'b00, ((w_yb >= o_ya) ? w_yb - o_ya : o_ya - w_yb)};
   assign o_yUp = o_ya < w_yb;

endmodule

// File: rtl/line_engine.sv
// Memory-mapped line rasteriser: latches endpoint/colour strobes and streams
// one Bresenham pixel per cycle to the framebuffer writer over valid/ready.
module line_engine
   import line_engine_pkg::*;
#(
   parameter int COORD_W = LE_COORD_W,
   parameter int COLOR_W = LE_COLOR_W
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic [31:0]        LE_color,
   input  logic [COORD_W-1:0] LE_point,
   input  logic               LE_color_valid,
   input  logic               LE_x0_valid,
   input  logic               LE_y0_valid,
   input  logic               LE_x1_valid,
   input  logic               LE_y1_valid,
   input  logic               LE_trigger,
   output logic               LE_ready,
   output logic               fb_wr_valid,
   input  logic               fb_wr_ready,
   output logic [COORD_W-1:0] fb_wr_x,
   output logic [COORD_W-1:0] fb_wr_y,
   output logic [COLOR_W-1:0] fb_wr_color
);

   localparam int SW = COORD_W + 2;

   le_state_t r_state;
   le_state_t w_nextState;

   logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;
   logic [COLOR_W-1:0] r_color;

   logic                 r_steep;
   logic                 r_yUp;
   logic [COORD_W-1:0]   r_x;
   logic [COORD_W-1:0]   r_y;
   logic [COORD_W-1:0]   r_xEnd;
   logic signed [SW-1:0] r_err;
   logic signed [SW-1:0] r_dx;
   logic signed [SW-1:0] r_dy;
   logic [COLOR_W-1:0]   r_drawColor;

   logic                 w_steep;
   logic                 w_yUp;
   logic [COORD_W-1:0]   w_xa;
   logic [COORD_W-1:0]   w_ya;
   logic [COORD_W-1:0]   w_xb;
   logic signed [SW-1:0] w_dx;
   logic signed [SW-1:0] w_dy;
   logic signed [SW-1:0] w_errSub;
   logic                 w_lastPix;

   generate
      if (COLOR_W < 32) begin : g_colorPad
         logic w_unusedColorBits;
         assign w_unusedColorBits = ^LE_color[31:COLOR_W];
      end
   endgenerate

   line_setup #(
      .COORD_W(COORD_W)
   ) u_setup (
      .i_x0    (r_x0),
      .i_y0    (r_y0),
      .i_x1    (r_x1),
      .i_y1    (r_y1),
      .o_steep (w_steep),
      .o_xa    (w_xa),
      .o_ya    (w_ya),
      .o_xb    (w_xb),
      .o_dx    (w_dx),
      .o_dy    (w_dy),
      .o_yUp   (w_yUp)
   );

   assign w_errSub  = r_err - r_dy;
   assign w_lastPix = (r_x == r_xEnd);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      LE_ready    = 1'b0;
      fb_wr_valid = 1'b0;
      case (r_state)
         IDLE: begin
            LE_ready = 1'b1;
            if (LE_trigger) w_nextState = SETUP;
         end
         SETUP: w_nextState = DRAW;
         DRAW: begin
            fb_wr_valid = 1'b1;
            if (fb_wr_ready && w_lastPix) w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Shadow registers stay writable while drawing; the stepper works only from
   // the copies captured in SETUP, so late strobes just prime the next line.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_x0        <= '0;
         r_y0        <= '0;
         r_x1        <= '0;
         r_y1        <= '0;
         r_color     <= '0;
         r_steep     <= 1'b0;
         r_yUp       <= 1'b0;
         r_x         <= '0;
         r_y         <= '0;
         r_xEnd      <= '0;
         r_err       <= '0;
         r_dx        <= '0;
         r_dy        <= '0;
         r_drawColor <= '0;
      end else begin
         if (LE_color_valid) r_color <= LE_color[COLOR_W-1:0];
         if (LE_x0_valid)    r_x0    <= LE_point;
         if (LE_y0_valid)    r_y0    <= LE_point;
         if (LE_x1_valid)    r_x1    <= LE_point;
         if (LE_y1_valid)    r_y1    <= LE_point;

         if (r_state == SETUP) begin
            r_steep     <= w_steep;
            r_yUp       <= w_yUp;
            r_x         <= w_xa;
            r_y         <= w_ya;
            r_xEnd      <= w_xb;
            r_dx        <= w_dx;
            r_dy        <= w_dy;
            r_err       <= w_dx >>> 1;
            r_drawColor <= r_color;
         end else if ((r_state == DRAW) && fb_wr_ready && !w_lastPix) begin
            r_x <= r_x + 1'b1;
            if (w_errSub[SW-1]) begin
               r_y   <= r_yUp ? r_y + 1'b1 : r_y - 1'b1;
               r_err <= w_errSub + r_dx;
            end else begin
               r_err <= w_errSub;
            end
         end
      end
   end

   assign fb_wr_x     = r_steep ? r_y : r_x;
   assign fb_wr_y     = r_steep ? r_x : r_y;
   assign fb_wr_color = r_drawColor;

endmodule

// File: tb/tb_line_engine.sv
// Randomised bench for line_engine: drives register strobes like the IO block
// and compares every accepted pixel against a textbook Bresenham model.
module tb_line_engine;

   localparam int CW = 10;
   localparam int KW = 24;

   logic          clock = 1'b0;
   logic          resetN;
   logic [31:0]   leColor;
   logic [CW-1:0] lePoint;
   logic          leColorValid, leX0Valid, leY0Valid, leX1Valid, leY1Valid;
   logic          leTrigger;
   logic          leReady;
   logic          fbValid;
   logic          fbReady;
   logic [CW-1:0] fbX;
   logic [CW-1:0] fbY;
   logic [KW-1:0] fbColor;

   int total = 0;
   int bad   = 0;

   int          shX0 = 0, shY0 = 0, shX1 = 0, shY1 = 0;
   logic [31:0] shColor = '0;
   logic [63:0] expQ[$];

   always #5 clock = ~clock;

   line_engine #(
      .COORD_W(CW),
      .COLOR_W(KW)
   ) dut (
      .Clock          (clock),
      .Reset          (resetN),
      .LE_color       (leColor),
      .LE_point       (lePoint),
      .LE_color_valid (leColorValid),
      .LE_x0_valid    (leX0Valid),
      .LE_y0_valid    (leY0Valid),
      .LE_x1_valid    (leX1Valid),
      .LE_y1_valid    (leY1Valid),
      .LE_trigger     (leTrigger),
      .LE_ready       (leReady),
      .fb_wr_valid    (fbValid),
      .fb_wr_ready    (fbReady),
      .fb_wr_x        (fbX),
      .fb_wr_y        (fbY),
      .fb_wr_color    (fbColor)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int iabs(int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [63:0] pix(int px, int py);
      return {20'd0, 10'(px), 10'(py), shColor[23:0]};
   endfunction

   // Reference: plain integer Bresenham over the current shadow values.
   function automatic void buildExpected();
      int ax = shX0, ay = shY0, bx = shX1, by = shY1;
      int t, dx, dy, err, ystep, y;
      bit steep;
      steep = iabs(by - ay) > iabs(bx - ax);
      if (steep) begin
         t = ax; ax = ay; ay = t;
         t = bx; bx = by; by = t;
      end
      if (ax > bx) begin
         t = ax; ax = bx; bx = t;
         t = ay; ay = by; by = t;
      end
      dx    = bx - ax;
      dy    = iabs(by - ay);
      err   = dx / 2;
      ystep = (ay < by) ? 1 : -1;
      y     = ay;
      expQ.delete();
      for (int x = ax; x <= bx; x++) begin
         expQ.push_back(steep ? pix(y, x) : pix(x, y));
         err -= dy;
         if (err < 0) begin
            y   += ystep;
            err += dx;
         end
      end
   endfunction

   // which: 0 colour, 1 x0, 2 y0, 3 x1, 4 y1. Strobes last one cycle.
   task automatic applyStimulus(input int which, input logic [31:0] value, input bit trig);
      case (which)
         0: begin leColor = value; leColorValid = 1'b1; shColor = value; end
         1: begin lePoint = value[CW-1:0]; leX0Valid = 1'b1; shX0 = int'(value[CW-1:0]); end
         2: begin lePoint = value[CW-1:0]; leY0Valid = 1'b1; shY0 = int'(value[CW-1:0]); end
         3: begin lePoint = value[CW-1:0]; leX1Valid = 1'b1; shX1 = int'(value[CW-1:0]); end
         default: begin lePoint = value[CW-1:0]; leY1Valid = 1'b1; shY1 = int'(value[CW-1:0]); end
      endcase
      leTrigger = trig;
      @(negedge clock);
      leColorValid = 1'b0;
      leX0Valid    = 1'b0;
      leY0Valid    = 1'b0;
      leX1Valid    = 1'b0;
      leY1Valid    = 1'b0;
      leTrigger    = 1'b0;
   endtask

   task automatic drawAndCheck(input int readyPct, input int stallAt, input int pokeCyc, input int pokeX0);
      int          cyc = 0;
      bit          heldValid = 0;
      bit          rdy;
      logic [63:0] held;
      logic [63:0] obs;
      checkOutput("setupReady", leReady, 0);
      checkOutput("setupValid", fbValid, 0);
      while (cyc < 5000) begin
         @(negedge clock);
         cyc++;
         leX0Valid = 1'b0;
         leTrigger = 1'b0;
         if (cyc == 1) checkOutput("latency", fbValid, 1);
         if (!fbValid) break;
         if (stallAt > 0 && cyc >= stallAt && cyc < stallAt + 3) rdy = 1'b0;
         else rdy = ($urandom_range(99) < readyPct);
         fbReady = rdy;
         if (cyc == pokeCyc) begin
            lePoint   = CW'(pokeX0);
            leX0Valid = 1'b1;
            leTrigger = 1'b1;
            shX0      = pokeX0;
         end
         checkOutput("busyReady", leReady, 0);
         obs = {20'd0, fbX, fbY, fbColor};
         if (heldValid) checkOutput("hold", obs, held);
         if (rdy) begin
            if (expQ.size() == 0) checkOutput("extraPix", obs, '1);
            else checkOutput("pixel", obs, expQ.pop_front());
            heldValid = 1'b0;
         end else begin
            held      = obs;
            heldValid = 1'b1;
         end
      end
      leX0Valid = 1'b0;
      leTrigger = 1'b0;
      checkOutput("drawDone", fbValid, 0);
      checkOutput("pixLeft", 64'(expQ.size()), 0);
      checkOutput("doneReady", leReady, 1);
      repeat (2) begin
         @(negedge clock);
         checkOutput("noRestart", fbValid, 0);
      end
   endtask

   task automatic runLine(input int x0, input int y0, input int x1, input int y1, input logic [31:0] color,
                          input int trigWhich, input int readyPct, input int stallAt,
                          input int pokeCyc, input int pokeX0);
      int pts[4];
      pts = '{x0, y0, x1, y1};
      checkOutput("idleReady", leReady, 1);
      applyStimulus(0, color, 1'b0);
      for (int w = 1; w <= 4; w++)
         if (w != trigWhich) applyStimulus(w, pts[w-1], 1'b0);
      applyStimulus(trigWhich, pts[trigWhich-1], 1'b1);
      buildExpected();
      drawAndCheck(readyPct, stallAt, pokeCyc, pokeX0);
   endtask

   task automatic runRetrigger();
      checkOutput("idleReady", leReady, 1);
      applyStimulus(3, shX1, 1'b1);
      buildExpected();
      drawAndCheck(100, 0, 0, 0);
   endtask

   initial begin
      resetN       = 1'b0;
      leColor      = '0;
      lePoint      = '0;
      leColorValid = 1'b0;
      leX0Valid    = 1'b0;
      leY0Valid    = 1'b0;
      leX1Valid    = 1'b0;
      leY1Valid    = 1'b0;
      leTrigger    = 1'b0;
      fbReady      = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("rstReady", leReady, 1);
      checkOutput("rstValid", fbValid, 0);
      checkOutput("rstPix", {20'd0, fbX, fbY, fbColor}, 0);
      resetN = 1'b1;
      @(negedge clock);

      runLine(0, 0, 3, 0, 32'h0000_FF00, 3, 100, 0, 0, 0);
      runLine(0, 0, 1, 3, 32'h0012_3456, 4, 100, 0, 0, 0);
      runLine(3, 0, 0, 0, 32'h0000_FF00, 1, 100, 0, 0, 0);
      runLine(5, 7, 5, 7, 32'hAB00_00CC, 2, 100, 0, 0, 0);
      runLine(10, 20, 30, 25, 32'h00C0_FFEE, 2, 100, 3, 6, 40);
      runRetrigger();

      for (int i = 0; i < 20; i++)
         runLine($urandom_range(63), $urandom_range(63), $urandom_range(63), $urandom_range(63),
                 $urandom, $urandom_range(1, 4), $urandom_range(40, 100), 0, 0, 0);
      for (int i = 0; i < 3; i++)
         runLine($urandom_range(1023), $urandom_range(1023), $urandom_range(1023), $urandom_range(1023),
                 $urandom, $urandom_range(1, 4), 100, 0, 0, 0);

      // Abort a long line with an asynchronous reset partway through.
      fbReady = 1'b1;
      checkOutput("idleReady", leReady, 1);
      applyStimulus(0, 32'h00FF_FFFF, 1'b0);
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      applyStimulus(4, 0, 1'b0);
      applyStimulus(3, 200, 1'b1);
      repeat (6) @(negedge clock);
      checkOutput("midValid", fbValid, 1);
      #2 resetN = 1'b0;
      #1;
      checkOutput("asyncValid", fbValid, 0);
      checkOutput("asyncReady", leReady, 1);
      @(negedge clock);
      resetN  = 1'b1;
      shX0    = 0;
      shY0    = 0;
      shX1    = 0;
      shY1    = 0;
      shColor = '0;
      repeat (5) begin
         @(negedge clock);
         checkOutput("postRstValid", fbValid, 0);
         checkOutput("postRstReady", leReady, 1);
      end
      runRetrigger();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/line_engine.md
Name: line_engine

Overview:
- Consumer end of the CPU's memory-mapped line-draw interface.
- Captures the colour, endpoint and trigger strobes that the IO block issues on stores to 0x80000028–0x8000004C.
- Rasterises a line with integer Bresenham and emits one pixel write per cycle to the framebuffer writer over a valid/ready port.
- Reports idle on `LE_ready`, which the IO block returns on loads from 0x80000024.

Parameters:
- `COORD_W`, 10, coordinate width in bits (screen 0..1023).
- `COLOR_W`, 24, pixel colour width; taken from `LE_color[COLOR_W-1:0]`.

Ports:
- `Clock` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset (asserted when 0).
- `LE_color` in 32: colour word; low `COLOR_W` bits are used.
- `LE_point` in `COORD_W`: coordinate value qualified by one of the four coordinate strobes.
- `LE_color_valid` in 1: latch `LE_color` into the colour register.
- `LE_x0_valid`, `LE_y0_valid`, `LE_x1_valid`, `LE_y1_valid` in 1 each: latch `LE_point` into the named endpoint register.
- `LE_trigger` in 1: start a draw. Always accompanies one coordinate strobe.
- `LE_ready` out 1: 1 when idle and able to accept a trigger.
- `fb_wr_valid` out 1: pixel write present.
- `fb_wr_ready` in 1: framebuffer writer accepts the pixel this cycle.
- `fb_wr_x` out `COORD_W`: pixel column.
- `fb_wr_y` out `COORD_W`: pixel row.
- `fb_wr_color` out `COLOR_W`: pixel colour.

Behaviour:
- Reset (`Reset`=0, async):
  - State goes to IDLE; `LE_ready`=1; `fb_wr_valid`=0.
  - `fb_wr_x`/`fb_wr_y`/`fb_wr_color`=0; shadow registers (x0, y0, x1, y1, colour)=0.
  - Reset mid-draw aborts the line. No further pixels are issued after deassertion.
- Shadow registers:
  - Update on their strobe in any state, including while busy.
  - A busy draw uses working copies taken at SETUP, so shadow updates never disturb it.
- Trigger with coordinate strobe in the same cycle:
  - The strobed coordinate is written first.
  - The draw uses the updated value: SETUP reads the shadow registers one cycle later.
- FSM:
  - IDLE: `LE_ready`=1. `LE_trigger` moves to SETUP next cycle. `LE_ready` is 0 from the cycle after the trigger.
  - SETUP, 1 cycle:
    - `steep` = |y1−y0| > |x1−x0|. If steep, swap x↔y for both endpoints.
    - If the resulting xa > xb, swap the endpoints.
    - dx = xb−xa; dy = |yb−ya|; err = dx>>1; ystep = +1 if ya<yb, else −1.
    - Current x = xa, current y = ya; latch colour. Go to DRAW.
  - DRAW:
    - `fb_wr_valid`=1. Pixel is (x,y) if not steep, (y,x) if steep.
    - On `fb_wr_valid`&&`fb_wr_ready`:
      - If x==xb, go to IDLE. `fb_wr_valid` is 0 and `LE_ready` is 1 the next cycle.
      - Otherwise err' = err − dy; if err'<0 then y += ystep and err' += dx; x += 1.
    - While `fb_wr_ready`=0, all `fb_wr_*` outputs hold stable (no change of x, y, err).
- `LE_trigger` outside IDLE is ignored and dropped; software polls `LE_ready`.
- Arithmetic:
  - err, dx, dy are signed `COORD_W`+2 bits.
  - x/y arithmetic is unsigned `COORD_W`; it never wraps for in-range endpoints.
- Degenerate line (both endpoints equal): exactly one pixel.
- Throughput: 1 pixel/cycle under continuous ready. Latency from trigger to first `fb_wr_valid` is 2 cycles.
- Pixel count = max(|dx|,|dy|)+1, emitted in ascending major-axis order.

Decomposition:
- Shared package `line_engine_pkg`:
  - FSM state encoding (IDLE, SETUP, DRAW).
  - `COORD_W` and `COLOR_W` defaults.
  - IO address constants 0x80000024–0x8000004C, shared with the IO block.
- One natural sub-module, `line_setup`: combinational steep/swap/abs/ystep computation feeding the SETUP registers.
- Stepper and FSM stay in `line_engine`.

Test Plan:
- Horizontal line: colour 0x00FF00, (0,0)→(3,0), trigger on x1 strobe, ready held 1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles, colour 0x00FF00. `LE_ready` 0 during the draw and 1 after.
- Steep line: (0,0)→(1,3) -> pixels (0,0),(0,1),(1,2),(1,3).
- Reversed endpoints: (3,0)→(0,0) -> same pixels as the horizontal case, x ascending.
- Degenerate line: (5,7)→(5,7) -> exactly one pixel (5,7); `LE_ready` returns to 1.
- Backpressure: `fb_wr_ready`=0 for 3 cycles mid-line -> outputs stable throughout, no skipped or duplicated pixel. A trigger and a new x0 issued while busy -> trigger ignored, current line unchanged; x0 holds the new value for the next draw.
- Reset: `Reset`=0 asserted mid-draw -> `fb_wr_valid`=0 and `LE_ready`=1 immediately (async). No pixels after release.
